// File: rtl/bridge_reg_responder.sv
// Bridge-side register responder in the core clock domain.
// Decodes a word-aligned window at base_addr and serves num_regs-1 R/W
// control registers plus one sticky W1C status register (last index).
// Ports:
//   clk, reset                  core clock, synchronous active-high reset
//   bridge_addr/wr/rd/wr_data   single-cycle bridge transaction strobes
//   bridge_rd_data, rd_hit      registered read data and its update pulse
//   ctrl_q, ctrl_wr             packed control registers and per-reg write strobes
//   event_in                    per-bit event pulses merged into status
module bridge_reg_responder #(
  parameter int unsigned num_regs         = 8,
  parameter logic [31:0] base_addr        = 32'h0000_0000,
  parameter logic [31:0] ctrl_reset_value = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  bridge_addr,
  input  logic                         bridge_wr,
  input  logic                         bridge_rd,
  input  logic [31:0]                  bridge_wr_data,
  output logic [31:0]                  bridge_rd_data,
  output logic                         rd_hit,
  output logic [(num_regs-1)*32-1:0]   ctrl_q,
  output logic [num_regs-2:0]          ctrl_wr,
  input  logic [31:0]                  event_in
);

  localparam int unsigned IDX_W    = $clog2(num_regs);
  localparam int unsigned NUM_CTRL = num_regs - 1;
  localparam int unsigned CTRL_W   = NUM_CTRL * 32;
  // Window covers num_regs words rounded up to a power of two.
  localparam logic [31:0] WIN_MASK = 32'((64'd1 << (IDX_W + 2)) - 64'd1);

  logic [CTRL_W-1:0]   ctrl_regs_q, ctrl_regs_d;
  logic [NUM_CTRL-1:0] ctrl_wr_q, ctrl_wr_d;
  logic [31:0]         status_q, status_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic                rd_hit_q, rd_hit_d;

  logic        hit;
  logic [31:0] idx_u;
  logic [31:0] rd_value;

  // Address decode.
  assign hit   = (bridge_addr & ~WIN_MASK) == base_addr;
  assign idx_u = 32'(bridge_addr[2 +: IDX_W]);

  // Read mux; status is sampled before this cycle's event merge, unmapped reads 0.
  always_comb begin
    rd_value = 32'h0000_0000;
    if (idx_u < NUM_CTRL) begin
      rd_value = 32'(ctrl_regs_q >> (idx_u * 32));
    end else if (idx_u == NUM_CTRL) begin
      rd_value = status_q;
    end
  end

  // Next-state logic; a write wins over a simultaneous read.
  always_comb begin
    ctrl_regs_d = ctrl_regs_q;
    ctrl_wr_d   = '0;
    status_d    = status_q | event_in;
    rd_data_d   = rd_data_q;
    rd_hit_d    = 1'b0;
    if (bridge_wr && hit) begin
      if (idx_u < NUM_CTRL) begin
        ctrl_regs_d = (ctrl_regs_q & ~(CTRL_W'(32'hFFFF_FFFF) << (idx_u * 32)))
                    | (CTRL_W'(bridge_wr_data) << (idx_u * 32));
        ctrl_wr_d   = NUM_CTRL'(1) << idx_u;
      end else if (idx_u == NUM_CTRL) begin
        // W1C with set-wins for a same-cycle event.
        status_d = (status_q & ~bridge_wr_data) | event_in;
      end
    end else if (bridge_rd && hit) begin
      rd_data_d = rd_value;
      rd_hit_d  = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_regs_q <= {NUM_CTRL{ctrl_reset_value}};
      ctrl_wr_q   <= '0;
      status_q    <= 32'h0000_0000;
      rd_data_q   <= 32'h0000_0000;
      rd_hit_q    <= 1'b0;
    end else begin
      ctrl_regs_q <= ctrl_regs_d;
      ctrl_wr_q   <= ctrl_wr_d;
      status_q    <= status_d;
      rd_data_q   <= rd_data_d;
      rd_hit_q    <= rd_hit_d;
    end
  end

  assign ctrl_q         = ctrl_regs_q;
  assign ctrl_wr        = ctrl_wr_q;
  assign bridge_rd_data = rd_data_q;
  assign rd_hit         = rd_hit_q;

endmodule

// File: tb/tb_bridge_reg_responder.sv
// Testbench for bridge_reg_responder: two instances with different geometry
// share one bridge bus; a behavioural model tracks each register bank.
module tb_bridge_reg_responder;

  localparam int unsigned NR_A   = 8;
  localparam int unsigned NR_B   = 6;
  localparam logic [31:0] BASE_B = 32'h0000_1000;
  localparam logic [31:0] RSTV_B = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, ev;
  logic        wr, rd;

  logic [31:0]            rd_data_a, rd_data_b;
  logic                   rd_hit_a, rd_hit_b;
  logic [(NR_A-1)*32-1:0] ctrl_q_a;
  logic [(NR_B-1)*32-1:0] ctrl_q_b;
  logic [NR_A-2:0]        ctrl_wr_a;
  logic [NR_B-2:0]        ctrl_wr_b;

  always #5 clk = ~clk;

  bridge_reg_responder #(.num_regs(NR_A), .base_addr(32'h0), .ctrl_reset_value(32'h0)) dut_a (
    .clk(clk), .reset(reset), .bridge_addr(addr), .bridge_wr(wr), .bridge_rd(rd),
    .bridge_wr_data(wdata), .bridge_rd_data(rd_data_a), .rd_hit(rd_hit_a),
    .ctrl_q(ctrl_q_a), .ctrl_wr(ctrl_wr_a), .event_in(ev)
  );

  bridge_reg_responder #(.num_regs(NR_B), .base_addr(BASE_B), .ctrl_reset_value(RSTV_B)) dut_b (
    .clk(clk), .reset(reset), .bridge_addr(addr), .bridge_wr(wr), .bridge_rd(rd),
    .bridge_wr_data(wdata), .bridge_rd_data(rd_data_b), .rd_hit(rd_hit_b),
    .ctrl_q(ctrl_q_b), .ctrl_wr(ctrl_wr_b), .event_in(ev)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, one slot per instance.
  int unsigned nr[2];
  logic [31:0] base[2], rstv[2];
  logic [31:0] m_ctrl[2][64];
  logic [31:0] m_stat[2], m_rd[2], m_wr[2];
  logic        m_hit[2];

  // Advance instance k's model by one clock with the current bus inputs.
  task automatic model_step(input int k);
    int unsigned size, idx;
    bit          hit;
    logic [31:0] old_stat, old_val;
    size = 4;
    while (size < nr[k] * 4) size = size * 2;
    if (reset) begin
      for (int i = 0; i < 64; i++) m_ctrl[k][i] = rstv[k];
      m_stat[k] = 0; m_rd[k] = 0; m_hit[k] = 0; m_wr[k] = 0;
      return;
    end
    hit = (addr - (addr % size)) == base[k];
    idx = (addr % size) / 4;
    old_stat = m_stat[k];
    if (idx >= nr[k])          old_val = 0;
    else if (idx == nr[k] - 1) old_val = old_stat;
    else                       old_val = m_ctrl[k][idx];
    m_wr[k]  = 0;
    m_hit[k] = 0;
    if (wr && hit && idx == nr[k] - 1) m_stat[k] = (old_stat & ~wdata) | ev;
    else                               m_stat[k] = old_stat | ev;
    if (wr && hit && idx < nr[k] - 1) begin
      m_ctrl[k][idx] = wdata;
      m_wr[k] = 32'(1) << idx;
    end
    if (rd && !wr && hit) begin
      m_rd[k]  = old_val;
      m_hit[k] = 1;
    end
  endtask

  task automatic check_outputs();
    check("rd_hit_a",  32'(rd_hit_a),  32'(m_hit[0]));
    check("rd_data_a", rd_data_a,      m_rd[0]);
    check("ctrl_wr_a", 32'(ctrl_wr_a), m_wr[0]);
    for (int i = 0; i < int'(NR_A) - 1; i++) check("ctrl_q_a", ctrl_q_a[i*32 +: 32], m_ctrl[0][i]);
    check("rd_hit_b",  32'(rd_hit_b),  32'(m_hit[1]));
    check("rd_data_b", rd_data_b,      m_rd[1]);
    check("ctrl_wr_b", 32'(ctrl_wr_b), m_wr[1]);
    for (int i = 0; i < int'(NR_B) - 1; i++) check("ctrl_q_b", ctrl_q_b[i*32 +: 32], m_ctrl[1][i]);
  endtask

  // Apply one cycle of bus inputs, clock, then compare against the model.
  task automatic bus(input logic r, input logic w, input logic rdv,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
    reset = r; wr = w; rd = rdv; addr = a; wdata = d; ev = e;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    logic        r, w, rdv;
    logic [31:0] a;
    int unsigned sel, op;

    nr[0] = NR_A;  base[0] = 32'h0; rstv[0] = 32'h0;
    nr[1] = NR_B;  base[1] = BASE_B; rstv[1] = RSTV_B;
    reset = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0; ev = '0;

    // Reset, then read every index of instance A.
    bus(1, 0, 0, 0, 0, 0);
    bus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      bus(0, 0, 1, 32'(i * 4), 0, 0);
      check("init_rd_data", rd_data_a, 32'h0);
      check("init_rd_hit", 32'(rd_hit_a), 32'h1);
    end

    // Write then back-to-back readback.
    bus(0, 1, 0, 32'h04, 32'hCAFE_F00D, 0);
    check("wr_ctrl1", ctrl_q_a[63:32], 32'hCAFE_F00D);
    check("wr_strobe", 32'(ctrl_wr_a), 32'h02);
    bus(0, 0, 1, 32'h04, 0, 0);
    check("rb_data", rd_data_a, 32'hCAFE_F00D);

    // Sticky status and W1C with set-wins.
    bus(0, 0, 0, 0, 0, 32'h5);
    bus(0, 0, 1, 32'h1C, 0, 0);
    check("sticky", rd_data_a, 32'h5);
    bus(0, 1, 0, 32'h1C, 32'h1, 0);
    bus(0, 0, 1, 32'h1C, 0, 0);
    check("w1c", rd_data_a, 32'h4);
    bus(0, 1, 0, 32'h1C, 32'h4, 32'h4);
    bus(0, 0, 1, 32'h1C, 0, 0);
    check("set_wins", rd_data_a, 32'h4);

    // Window miss on instance B keeps everything.
    bus(0, 1, 0, 32'h1000, 32'h1234_5678, 0);
    bus(0, 0, 1, 32'h1000, 0, 0);
    check("miss_prior", rd_data_b, 32'h1234_5678);
    bus(0, 1, 0, 32'h2000, 32'hFFFF_FFFF, 0);
    check("miss_wr_strobe", 32'(ctrl_wr_b), 32'h0);
    bus(0, 0, 1, 32'h2000, 0, 0);
    check("miss_rd_hit", 32'(rd_hit_b), 32'h0);
    check("miss_rd_data", rd_data_b, 32'h1234_5678);
    check("miss_ctrl", ctrl_q_b[31:0], 32'h1234_5678);

    // Unmapped index and write/read collision on instance B.
    bus(0, 0, 1, 32'h1018, 0, 0);
    check("unmapped_data", rd_data_b, 32'h0);
    check("unmapped_hit", 32'(rd_hit_b), 32'h1);
    bus(0, 1, 1, 32'h1000, 32'hA5, 0);
    check("collide_ctrl", ctrl_q_b[31:0], 32'hA5);
    check("collide_hit", 32'(rd_hit_b), 32'h0);
    check("collide_data", rd_data_b, 32'h0);

    // Reset wins over a same-cycle write.
    bus(0, 0, 1, 32'h04, 0, 0);
    bus(1, 1, 0, 32'h08, 32'h55, 0);
    check("rst_ctrl2", ctrl_q_a[95:64], 32'h0);
    check("rst_strobe", 32'(ctrl_wr_a), 32'h0);
    check("rst_rd_data", rd_data_a, 32'h0);
    check("rst_ctrl_b", ctrl_q_b[31:0], RSTV_B);

    // Randomized traffic across both windows and misses.
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 63) == 0);
      sel = $urandom_range(0, 9);
      if (sel < 4)      a = 32'($urandom_range(0, 31));
      else if (sel < 8) a = BASE_B + 32'($urandom_range(0, 31));
      else              a = $urandom;
      op  = $urandom_range(0, 9);
      w   = (op < 4) || (op == 9);
      rdv = (op >= 4);
      bus(r, w, rdv, a, $urandom, $urandom & $urandom & $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
